// File: rtl/dot_product_chunked_array.sv
// Chunked sigma*J dot-product engine: each vector arrives as NUM_CHUNKS beats, every beat is
// reduced per lane into a partial register, then accumulated and handed out through a valid/ready register.
module dot_product_chunked_array #(
    parameter int VECTOR_SIZE     = 256,
    parameter int CHUNK           = 32,
    parameter int J_ELEMENT_WIDTH = 4,
    parameter int J_SIGNED        = 0,
    parameter int LANES           = 16,
    parameter int ACC_WIDTH       = J_ELEMENT_WIDTH + 1 + $clog2(VECTOR_SIZE),
    localparam int NUM_CHUNKS     = VECTOR_SIZE / CHUNK,
    localparam int CIDX_W         = $clog2(NUM_CHUNKS)
) (
    input  logic                                               clk,
    input  logic                                               rst_n,
    input  logic                                               clear,
    input  logic                                               cfg_binary,
    input  logic                                               in_valid,
    output logic                                               in_ready,
    input  logic [CHUNK-1:0]                                   in_sigma,
    input  logic [LANES-1:0][CHUNK-1:0][J_ELEMENT_WIDTH-1:0]   in_j,
    output logic [CIDX_W-1:0]                                  chunk_idx,
    output logic                                               out_valid,
    input  logic                                               out_ready,
    output logic [LANES-1:0][ACC_WIDTH-1:0]                    dot_outs
);

    logic [CIDX_W-1:0]                 chunk_q;
    logic                              mode_q;
    logic                              mode_cur;
    logic                              p_valid;
    logic                              p_last;
    logic                              last_beat;
    logic                              stall;
    logic                              accept;
    logic                              advance;
    logic                              out_valid_q;
    logic [LANES-1:0][ACC_WIDTH-1:0]   partial_d;
    logic [LANES-1:0][ACC_WIDTH-1:0]   partial_q;
    logic [LANES-1:0][ACC_WIDTH-1:0]   acc_q;
    logic [LANES-1:0][ACC_WIDTH-1:0]   dot_q;

    function automatic logic [ACC_WIDTH-1:0] j_ext(input logic [J_ELEMENT_WIDTH-1:0] j);
        if (J_SIGNED != 0)
            return ACC_WIDTH'($signed(j));
        else
            return ACC_WIDTH'(j);
    endfunction

    // The first beat of a vector uses cfg_binary directly; later beats use the latched copy.
    assign mode_cur  = (chunk_q == '0) ? cfg_binary : mode_q;
    assign last_beat = (chunk_q == CIDX_W'(NUM_CHUNKS - 1));
    assign stall     = p_valid && p_last && out_valid_q && !out_ready;
    assign in_ready  = !stall;
    assign accept    = in_valid && !stall && !clear;
    assign advance   = p_valid && !stall && !clear;

    assign chunk_idx = chunk_q;
    assign out_valid = out_valid_q;
    assign dot_outs  = dot_q;

    always_comb begin
        partial_d = '0;
        for (int l = 0; l < LANES; l++) begin
            for (int k = 0; k < CHUNK; k++) begin
                if (in_sigma[k])
                    partial_d[l] = partial_d[l] + j_ext(in_j[l][k]);
                else if (!mode_cur)
                    partial_d[l] = partial_d[l] - j_ext(in_j[l][k]);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chunk_q   <= '0;
            mode_q    <= 1'b0;
            p_valid   <= 1'b0;
            p_last    <= 1'b0;
            partial_q <= '0;
        end else if (clear) begin
            chunk_q <= '0;
            p_valid <= 1'b0;
        end else if (!stall) begin
            p_valid <= accept;
            if (accept) begin
                partial_q <= partial_d;
                p_last    <= last_beat;
                chunk_q   <= last_beat ? '0 : chunk_q + 1'b1;
                if (chunk_q == '0)
                    mode_q <= cfg_binary;
            end
        end
    end

    // A clear drops a final partial sitting in stage P, so no result is produced from it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q       <= '0;
            dot_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            if (out_valid_q && out_ready)
                out_valid_q <= 1'b0;
            if (clear) begin
                acc_q <= '0;
            end else if (advance) begin
                if (p_last) begin
                    for (int l = 0; l < LANES; l++)
                        dot_q[l] <= acc_q[l] + partial_q[l];
                    out_valid_q <= 1'b1;
                    acc_q       <= '0;
                end else begin
                    for (int l = 0; l < LANES; l++)
                        acc_q[l] <= acc_q[l] + partial_q[l];
                end
            end
        end
    end

endmodule

// File: tb/tb_dot_product_chunked_array.sv
// Bench for dot_product_chunked_array: unsigned-J and signed-J instances share stimulus and are
// checked every cycle against a transaction-level model, plus literal results for directed vectors.
module tb_dot_product_chunked_array;

    localparam int VS = 256;
    localparam int CH = 32;
    localparam int JW = 4;
    localparam int LN = 16;
    localparam int AW = JW + 1 + $clog2(VS);
    localparam int NC = VS / CH;
    localparam int CW = $clog2(NC);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clear = 1'b0;
    logic cfg_binary = 1'b0;
    logic in_valid = 1'b0;
    logic out_ready = 1'b0;
    logic [CH-1:0] in_sigma = '0;
    logic [LN-1:0][CH-1:0][JW-1:0] in_j = '0;

    logic in_ready_u, in_ready_s, out_valid_u, out_valid_s;
    logic [CW-1:0] chunk_idx_u, chunk_idx_s;
    logic [LN-1:0][AW-1:0] dot_u, dot_s;

    dot_product_chunked_array #(.J_SIGNED(0)) u_dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .cfg_binary(cfg_binary),
        .in_valid(in_valid), .in_ready(in_ready_u), .in_sigma(in_sigma), .in_j(in_j),
        .chunk_idx(chunk_idx_u), .out_valid(out_valid_u), .out_ready(out_ready), .dot_outs(dot_u));

    dot_product_chunked_array #(.J_SIGNED(1)) u_sdut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .cfg_binary(cfg_binary),
        .in_valid(in_valid), .in_ready(in_ready_s), .in_sigma(in_sigma), .in_j(in_j),
        .chunk_idx(chunk_idx_s), .out_valid(out_valid_s), .out_ready(out_ready), .dot_outs(dot_s));

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int  acc_m[2][LN];
    int  pend_m[2][LN];
    int  out_m[2][LN];
    bit  pend, ov, mode_m, m_stall, m_now;
    int  cnt;
    int  got_u[$];
    int  got_s[$];

    function automatic int jval(input int sgn, input logic [JW-1:0] j);
        return (sgn != 0) ? int'($signed(j)) : int'(j);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend = 0; ov = 0; mode_m = 0; cnt = 0;
            for (int s = 0; s < 2; s++)
                for (int l = 0; l < LN; l++) begin
                    acc_m[s][l] = 0; pend_m[s][l] = 0; out_m[s][l] = 0;
                end
        end else begin
            m_stall = pend && ov && !out_ready;
            if (ov && out_ready) begin
                got_u.push_back(int'($signed(dot_u[0])));
                got_s.push_back(int'($signed(dot_s[0])));
            end
            if (pend && !clear && !m_stall) begin
                out_m = pend_m;
                ov = 1;
                pend = 0;
            end else if (ov && out_ready) begin
                ov = 0;
            end
            if (clear) begin
                pend = 0;
                cnt = 0;
                for (int s = 0; s < 2; s++)
                    for (int l = 0; l < LN; l++) acc_m[s][l] = 0;
            end else if (in_valid && !m_stall) begin
                m_now = (cnt == 0) ? cfg_binary : mode_m;
                if (cnt == 0) mode_m = cfg_binary;
                for (int s = 0; s < 2; s++)
                    for (int l = 0; l < LN; l++)
                        for (int k = 0; k < CH; k++) begin
                            if (in_sigma[k]) acc_m[s][l] += jval(s, in_j[l][k]);
                            else if (!m_now) acc_m[s][l] -= jval(s, in_j[l][k]);
                        end
                cnt++;
                if (cnt == NC) begin
                    pend = 1;
                    pend_m = acc_m;
                    cnt = 0;
                    for (int s = 0; s < 2; s++)
                        for (int l = 0; l < LN; l++) acc_m[s][l] = 0;
                end
            end
        end
    end

    task automatic chk_lanes(input string name, input logic [LN-1:0][AW-1:0] d, input int s);
        int bl = 0;
        for (int l = 0; l < LN; l++)
            if (int'($signed(d[l])) != out_m[s][l]) begin
                bl = l;
                break;
            end
        chk(name, int'($signed(d[bl])), out_m[s][bl]);
    endtask

    always @(posedge clk) begin
        #1;
        if (rst_n) begin
            chk("out_valid_u", int'(out_valid_u), int'(ov));
            chk("out_valid_s", int'(out_valid_s), int'(ov));
            chk("in_ready_u", int'(in_ready_u), int'(!(pend && ov && !out_ready)));
            chk("in_ready_s", int'(in_ready_s), int'(!(pend && ov && !out_ready)));
            chk("chunk_idx_u", int'(chunk_idx_u), cnt);
            chk("chunk_idx_s", int'(chunk_idx_s), cnt);
            if (ov) begin
                chk_lanes("dot_u", dot_u, 0);
                chk_lanes("dot_s", dot_s, 1);
            end
        end
    end

    // ---------------- stimulus ----------------
    bit or_rand = 0;

    task automatic drive_or();
        if (or_rand) out_ready = ($urandom_range(0, 2) != 0);
    endtask

    task automatic beat(input logic [CH-1:0] sig, input int jfill, input logic cfg);
        bit done = 0;
        int tries = 0;
        while (!done) begin
            @(negedge clk);
            drive_or();
            clear = 0;
            in_valid = 1;
            in_sigma = sig;
            cfg_binary = cfg;
            for (int l = 0; l < LN; l++)
                for (int k = 0; k < CH; k++)
                    in_j[l][k] = (jfill < 0) ? JW'($urandom_range(0, 15)) : jfill[JW-1:0];
            #1;
            if (in_ready_u) done = 1;
            else if (++tries > 200) begin
                chk("beat_accept_timeout", int'(in_ready_u), 1);
                done = 1;
            end
        end
        @(posedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            drive_or();
            in_valid = 0;
            clear = 0;
        end
    endtask

    task automatic vec(input logic [CH-1:0] sig, input int jfill, input logic cfg);
        repeat (NC) beat(sig, jfill, cfg);
    endtask

    task automatic expect_res(input string name, input int eu, input int es);
        int n = 0;
        while (got_u.size() == 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (got_u.size() == 0) chk({name, "_timeout"}, got_u.size(), 1);
        else begin
            chk({name, "_u"}, got_u.pop_front(), eu);
            chk({name, "_s"}, got_s.pop_front(), es);
        end
    endtask

    logic [CH-1:0] ones, zeros, alt;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        ones = '1;
        zeros = '0;
        alt = 32'hAAAA_AAAA;

        #2;
        chk("rst_out_valid", int'(out_valid_u), 0);
        chk("rst_dot", int'($signed(dot_u[0])), 0);
        chk("rst_chunk_idx", int'(chunk_idx_u), 0);
        chk("rst_in_ready", int'(in_ready_u), 1);
        repeat (2) @(negedge clk);
        rst_n = 1;
        out_ready = 1;

        // unsigned/signed spin with J=15 (signed view: -1)
        vec(ones, 15, 0);
        @(negedge clk);
        in_valid = 0;
        chk("lat_before", int'(out_valid_u), 0);
        @(posedge clk);
        #1 chk("lat_after", int'(out_valid_u), 1);
        expect_res("j15_ones", 3840, -256);
        vec(zeros, 15, 0);
        idle(1);
        expect_res("j15_zeros", -3840, 256);

        // J=8 (signed view: -8)
        vec(ones, 8, 0);
        idle(1);
        expect_res("j8_ones", 2048, -2048);
        vec(zeros, 8, 0);
        idle(1);
        expect_res("j8_zeros", -2048, 2048);

        // mode selection and mid-vector toggling
        vec(alt, 3, 1);
        idle(1);
        expect_res("mode_binary", 384, 384);
        vec(alt, 3, 0);
        idle(1);
        expect_res("mode_spin", 0, 0);
        beat(alt, 3, 1);
        repeat (NC - 1) beat(alt, 3, 0);
        idle(1);
        expect_res("mode_toggle", 384, 384);

        // backpressure: A held, B's final beat accepted, then input stalls
        idle(2);
        out_ready = 0;
        vec(ones, 15, 0);
        vec(zeros, 15, 0);
        @(negedge clk);
        in_valid = 1;
        #1;
        chk("bp_in_ready", int'(in_ready_u), 0);
        chk("bp_A_held", int'($signed(dot_u[0])), 3840);
        chk("bp_no_early", got_u.size(), 0);
        idle(3);
        @(negedge clk) out_ready = 1;
        @(negedge clk) out_ready = 0;
        expect_res("bp_A", 3840, -256);
        idle(3);
        chk("bp_B_held_valid", int'(out_valid_u), 1);
        chk("bp_B_held", int'($signed(dot_u[0])), -3840);
        @(negedge clk) out_ready = 1;
        @(negedge clk) out_ready = 0;
        expect_res("bp_B", -3840, 256);
        idle(4);
        chk("bp_no_dup", got_u.size(), 0);
        out_ready = 1;

        // clear mid-vector
        repeat (3) beat(ones, 15, 0);
        @(negedge clk);
        in_valid = 1;
        clear = 1;
        @(negedge clk);
        clear = 0;
        in_valid = 0;
        chk("clr_chunk_idx", int'(chunk_idx_u), 0);
        vec(ones, 1, 0);
        idle(1);
        expect_res("clr_then_ones", 256, 256);

        // clear coinciding with the final partial drops the result
        vec(ones, 15, 0);
        @(negedge clk);
        in_valid = 0;
        clear = 1;
        idle(4);
        chk("clr_drop_count", got_u.size(), 0);
        chk("clr_drop_valid", int'(out_valid_u), 0);

        // asynchronous reset mid-operation with a held result
        out_ready = 0;
        vec(ones, 15, 0);
        repeat (3) beat(ones, 15, 0);
        @(negedge clk);
        in_valid = 0;
        #2 rst_n = 0;
        #1;
        chk("arst_out_valid", int'(out_valid_u), 0);
        chk("arst_dot", int'($signed(dot_u[0])), 0);
        chk("arst_chunk_idx", int'(chunk_idx_u), 0);
        @(negedge clk);
        rst_n = 1;
        #1 chk("arst_in_ready", int'(in_ready_u), 1);
        got_u.delete();
        got_s.delete();

        // randomized traffic: random J/sigma/mode, gaps, backpressure, occasional clear
        or_rand = 1;
        for (int v = 0; v < 40; v++) begin
            for (int b = 0; b < NC; b++) begin
                beat(CH'($urandom), -1, 1'($urandom_range(0, 1)));
                if ($urandom_range(0, 3) == 0) idle(1);
                if ($urandom_range(0, 31) == 0) begin
                    @(negedge clk);
                    drive_or();
                    in_valid = 1'($urandom_range(0, 1));
                    clear = 1;
                end
            end
        end
        or_rand = 0;
        out_ready = 1;
        idle(6);
        chk("final_drained", int'(out_valid_u), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dot_product_chunked_array.md
Name: dot_product_chunked_array

Overview:
- Multi-lane sigma·J dot-product engine for the Ising-style update path.
- Successor to the fully parallel adder-tree array. Each vector of VECTOR_SIZE elements arrives as NUM_CHUNKS beats of CHUNK elements.
- Each beat is reduced per lane, registered, and accumulated across beats.
- Results leave through a valid/ready output register with backpressure. Supports unsigned/signed J and spin (±1) or binary ({0,1}) sigma interpretation.

Parameters:
- VECTOR_SIZE, 256, elements per full dot product.
- CHUNK, 32, elements per input beat. Must divide VECTOR_SIZE; NUM_CHUNKS = VECTOR_SIZE/CHUNK ≥ 2.
- J_ELEMENT_WIDTH, 4, bits per J element.
- J_SIGNED, 0, 0 = J unsigned, 1 = J two's complement.
- LANES, 16, parallel columns.
- ACC_WIDTH, J_ELEMENT_WIDTH+1+$clog2(VECTOR_SIZE), signed result width.

Ports:
- clk  in  1  clock (single clock domain).
- rst_n  in  1  reset, asynchronous, active-low.
- clear  in  1  synchronous flush of in-flight vector.
- cfg_binary  in  1  0 = spin mode (sigma 0 → −J), 1 = binary mode (sigma 0 → 0). Sampled on the first beat of a vector.
- in_valid  in  1  beat valid.
- in_ready  out  1  beat accepted when in_valid && in_ready.
- in_sigma  in  CHUNK  sigma bits of this beat; bit k pairs with element k.
- in_j  in  [LANES][CHUNK] x J_ELEMENT_WIDTH  J elements per lane for this beat.
- chunk_idx  out  $clog2(NUM_CHUNKS)  index of the next beat to be accepted.
- out_valid  out  1  result valid.
- out_ready  in  1  result consumed when out_valid && out_ready.
- dot_outs  out  [LANES] signed ACC_WIDTH  per-lane result.

Behaviour:
- Reset (async, rst_n=0): partial regs, accumulators, chunk_idx, dot_outs cleared to 0; out_valid=0; latched mode=0. in_ready is 1 (derived from cleared state).
- Term per element: sigma=1 → +J; sigma=0 → −J (spin) or 0 (binary). J is sign- or zero-extended per J_SIGNED before negation.
- All arithmetic is at ACC_WIDTH. No overflow is possible at the defaults.
- Stage P (partial): on accept, the per-lane CHUNK-term sum is registered with p_valid and p_last.
  - p_last = (chunk_idx == NUM_CHUNKS-1).
  - chunk_idx increments and wraps to 0 after the last beat.
- Stage A (accumulate): when p_valid and the stage advances, acc += partial.
  - If p_last: dot_outs ← acc + partial, out_valid ← 1, acc ← 0.
- Mode latch: cfg_binary is captured when chunk_idx == 0 and the beat is accepted. It applies to all beats of that vector.
- Stall rule: stall = p_valid && p_last && out_valid && !out_ready.
  - While stalled, Stage P holds and in_ready = 0. Otherwise in_ready = 1.
- Output: out_valid stays high and dot_outs stay stable until the handshake.
  - If out_ready is high in the same cycle a new result is produced, the new result replaces the old with no bubble. out_valid stays 1.
- Latency: last beat accepted at edge E → out_valid high after edge E+1. Back-to-back vectors sustain 1 beat/cycle with out_ready=1.
- clear=1 (synchronous, priority over in_valid):
  - p_valid, acc and chunk_idx are zeroed; no beat is accepted that cycle.
  - A pending out_valid result is kept.
- Simultaneous clear and final partial: the partial is dropped and no result is produced.
- Reset mid-operation: everything is dropped, including a held result.

Test Plan:
- Reset: assert rst_n=0 mid-vector → out_valid=0, dot_outs=0, chunk_idx=0 immediately (asynchronous). After release, in_ready=1.
- Unsigned spin: J=15 all lanes, 8 beats, out_ready=1.
  - sigma all 1 → every lane 3840, out_valid 1 cycle after last beat.
  - Repeat with sigma all 0 → −3840.
- Signed (J_SIGNED=1): J=4'h8 (−8).
  - sigma all 1 → −2048.
  - sigma all 0 → +2048.
- Mode: J=3, sigma bit k = k%2.
  - cfg_binary=1 → 384; cfg_binary=0 → 0.
  - Toggling cfg_binary mid-vector has no effect.
- Backpressure: out_ready=0, send vector A (all +15, result 3840) then vector B (sigma all 0, result −3840) back-to-back.
  - A is held.
  - B's final beat is accepted, then in_ready=0.
  - Pulse out_ready → A seen, then B seen on the next handshake. No loss or duplication.
- Clear: 3 beats of J=15/sigma=1, clear, then 8 beats of J=1/sigma=1 → 256, chunk_idx=0 after clear.
